// File: rtl/bram_arbiter_pkg.sv
// Shared types and defaults for the two-requester BRAM arbiter.
// Requester ids, default geometry and the read-pending tag payload.
package bram_arbiter_pkg;

  localparam int unsigned DEF_ADDR_SZ = 8;
  localparam int unsigned DEF_DATA_SZ = 16;
  localparam int unsigned NUM_REQ     = 2;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  // Read result tag travelling alongside the BRAM read latency
  typedef struct packed {
    logic valid;
    logic id;
  } rd_tag_t;

  function automatic logic [NUM_REQ-1:0] id_onehot(input logic id);
    return (id == REQ1) ? NUM_REQ'(2'b10) : NUM_REQ'(2'b01);
  endfunction

endpackage

// File: rtl/bram_arbiter_arb2_grant.sv
// Combinational two-way grant; BRAM_ARB_RR_EN selects round-robin with a
// preference register, otherwise requester 0 always wins contention.
module bram_arbiter_arb2_grant
  import bram_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] eligible,
  output logic       grant_valid_c,
  output logic       grant_id_c
);

`ifdef BRAM_ARB_RR_EN
  logic pref;

  always_comb begin
    grant_valid_c = |eligible;
    grant_id_c    = REQ0;
    if (eligible == 2'b11) begin
      grant_id_c = pref;
    end else if (eligible[1]) begin
      grant_id_c = REQ1;
    end
  end

  // Preference moves to the requester that did not just win
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pref <= REQ0;
    end else if (grant_valid_c) begin
      pref <= ~grant_id_c;
    end
  end
`else
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst_n;

  always_comb begin
    grant_valid_c = |eligible;
    grant_id_c    = eligible[0] ? REQ0 : REQ1;
  end
`endif

endmodule

// File: rtl/bram_arbiter.sv
// Two-requester arbiter/sequencer for a shared 256x16 simple-dual-port BRAM.
// Define BRAM_ARB_RR_EN for round-robin arbitration (default: fixed priority, requester 0 first).
module bram_arbiter
  import bram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_SZ = DEF_ADDR_SZ,
  parameter int unsigned DATA_SZ = DEF_DATA_SZ
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_req0,
  input  logic               i_req1,
  input  logic               i_wr0,
  input  logic               i_wr1,
  input  logic [ADDR_SZ-1:0] i_addr0,
  input  logic [ADDR_SZ-1:0] i_addr1,
  input  logic [DATA_SZ-1:0] i_wdata0,
  input  logic [DATA_SZ-1:0] i_wdata1,
  output logic               o_ack0,
  output logic               o_ack1,
  output logic               o_rvalid0,
  output logic               o_rvalid1,
  output logic [DATA_SZ-1:0] o_rdata,
  output logic               o_bram_wr_en,
  output logic [ADDR_SZ-1:0] o_bram_waddr,
  output logic [DATA_SZ-1:0] o_bram_wdata,
  output logic               o_bram_rd_en,
  output logic [ADDR_SZ-1:0] o_bram_raddr,
  input  logic [DATA_SZ-1:0] i_bram_rdata
);

  logic [1:0]         eligible_c;
  logic               grant_valid_c;
  logic               grant_id_c;
  logic [1:0]         grant_oh_c;
  logic               sel_wr_c;
  logic [ADDR_SZ-1:0] sel_addr_c;
  logic [DATA_SZ-1:0] sel_wdata_c;
  rd_tag_t            rd_pend;

  // A requester whose ack is visible this cycle is masked to block a double grant
  assign eligible_c = {i_req1 & ~o_ack1, i_req0 & ~o_ack0};

  bram_arbiter_arb2_grant u_grant (
    .clk           (i_clk),
    .rst_n         (i_rst_n),
    .eligible      (eligible_c),
    .grant_valid_c (grant_valid_c),
    .grant_id_c    (grant_id_c)
  );

  always_comb begin
    grant_oh_c  = grant_valid_c ? id_onehot(grant_id_c) : 2'b00;
    sel_wr_c    = (grant_id_c == REQ1) ? i_wr1    : i_wr0;
    sel_addr_c  = (grant_id_c == REQ1) ? i_addr1  : i_addr0;
    sel_wdata_c = (grant_id_c == REQ1) ? i_wdata1 : i_wdata0;
  end

  // Command launch; address/data registers hold their last value while idle
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_ack0       <= 1'b0;
      o_ack1       <= 1'b0;
      o_bram_wr_en <= 1'b0;
      o_bram_rd_en <= 1'b0;
      o_bram_waddr <= '0;
      o_bram_wdata <= '0;
      o_bram_raddr <= '0;
    end else begin
      o_ack0       <= grant_oh_c[0];
      o_ack1       <= grant_oh_c[1];
      o_bram_wr_en <= grant_valid_c & sel_wr_c;
      o_bram_rd_en <= grant_valid_c & ~sel_wr_c;
      if (grant_valid_c && sel_wr_c) begin
        o_bram_waddr <= sel_addr_c;
        o_bram_wdata <= sel_wdata_c;
      end
      if (grant_valid_c && !sel_wr_c) begin
        o_bram_raddr <= sel_addr_c;
      end
    end
  end

  // Read tag follows the BRAM sample cycle so rvalid lines up with its output register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rd_pend   <= '0;
      o_rvalid0 <= 1'b0;
      o_rvalid1 <= 1'b0;
    end else begin
      rd_pend.valid <= grant_valid_c & ~sel_wr_c;
      rd_pend.id    <= grant_id_c;
      o_rvalid0     <= rd_pend.valid && (rd_pend.id == REQ0);
      o_rvalid1     <= rd_pend.valid && (rd_pend.id == REQ1);
    end
  end

  assign o_rdata = i_bram_rdata;

endmodule

// File: tb/tb_bram_arbiter.sv
// Scoreboard bench for bram_arbiter: random and directed requesters, a behavioural
// memory/arbitration model and a negedge monitor. Honours BRAM_ARB_RR_EN.
module tb_bram_arbiter;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    req;
  logic [1:0]    wr;
  logic [AW-1:0] addr [2];
  logic [DW-1:0] wdata [2];

  logic          ack0, ack1, rvalid0, rvalid1;
  logic [DW-1:0] rdata;
  logic          bram_wr_en, bram_rd_en;
  logic [AW-1:0] bram_waddr, bram_raddr;
  logic [DW-1:0] bram_wdata;
  logic [DW-1:0] bram_rdata = '0;
  logic [DW-1:0] bram_mem [256] = '{default: '0};

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bram_arbiter dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req0       (req[0]),
    .i_req1       (req[1]),
    .i_wr0        (wr[0]),
    .i_wr1        (wr[1]),
    .i_addr0      (addr[0]),
    .i_addr1      (addr[1]),
    .i_wdata0     (wdata[0]),
    .i_wdata1     (wdata[1]),
    .o_ack0       (ack0),
    .o_ack1       (ack1),
    .o_rvalid0    (rvalid0),
    .o_rvalid1    (rvalid1),
    .o_rdata      (rdata),
    .o_bram_wr_en (bram_wr_en),
    .o_bram_waddr (bram_waddr),
    .o_bram_wdata (bram_wdata),
    .o_bram_rd_en (bram_rd_en),
    .o_bram_raddr (bram_raddr),
    .i_bram_rdata (bram_rdata)
  );

  // Simple-dual-port BRAM, registered read
  always @(posedge clk) begin
    if (bram_wr_en) bram_mem[bram_waddr] <= bram_wdata;
    if (bram_rd_en) bram_rdata <= bram_mem[bram_raddr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %0h want %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model + monitor ----------------
  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } rd_exp_t;

  rd_exp_t       q0[$];
  rd_exp_t       q1[$];
  logic [DW-1:0] model_mem [256];
  logic [1:0]    exp_ack;
  logic          exp_wr_en, exp_rd_en;
  logic [AW-1:0] exp_waddr, exp_raddr;
  logic [DW-1:0] exp_wdata;
  logic          last_grant;
  int            cyc;

  initial begin
    logic [1:0] elig;
    logic       g;
    logic       v;
    for (int i = 0; i < 256; i++) model_mem[i] = '0;
    exp_ack = 2'b00; exp_wr_en = 1'b0; exp_rd_en = 1'b0;
    exp_waddr = '0; exp_raddr = '0; exp_wdata = '0;
    last_grant = 1'b1;
    cyc = 0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      cyc++;
      check("ack0", 32'(ack0), 32'(exp_ack[0]));
      check("ack1", 32'(ack1), 32'(exp_ack[1]));
      check("wr_en", 32'(bram_wr_en), 32'(exp_wr_en));
      check("rd_en", 32'(bram_rd_en), 32'(exp_rd_en));
      if (exp_wr_en) begin
        check("waddr", 32'(bram_waddr), 32'(exp_waddr));
        check("wdata", 32'(bram_wdata), 32'(exp_wdata));
      end
      if (exp_rd_en) check("raddr", 32'(bram_raddr), 32'(exp_raddr));

      v = (q0.size() > 0) && (q0[0].due == cyc);
      check("rvalid0", 32'(rvalid0), 32'(v));
      if (v) begin
        check("rdata0", 32'(rdata), 32'(q0[0].data));
        void'(q0.pop_front());
      end
      v = (q1.size() > 0) && (q1[0].due == cyc);
      check("rvalid1", 32'(rvalid1), 32'(v));
      if (v) begin
        check("rdata1", 32'(rdata), 32'(q1[0].data));
        void'(q1.pop_front());
      end

      // Decide what the arbiter must launch at the coming edge
      if (!rst_n) begin
        exp_ack = 2'b00; exp_wr_en = 1'b0; exp_rd_en = 1'b0;
        exp_waddr = '0; exp_raddr = '0; exp_wdata = '0;
        q0.delete(); q1.delete();
        last_grant = 1'b1;
      end else begin
        elig = req & ~exp_ack;
        v = |elig;
        if (elig == 2'b11) begin
`ifdef BRAM_ARB_RR_EN
          g = ~last_grant;
`else
          g = 1'b0;
`endif
        end else begin
          g = elig[1];
        end
        exp_ack = 2'b00; exp_wr_en = 1'b0; exp_rd_en = 1'b0;
        if (v) begin
          exp_ack[g] = 1'b1;
          last_grant = g;
          if (wr[g]) begin
            exp_wr_en = 1'b1;
            exp_waddr = addr[g];
            exp_wdata = wdata[g];
            model_mem[addr[g]] = wdata[g];
          end else begin
            exp_rd_en = 1'b1;
            exp_raddr = addr[g];
            if (g) q1.push_back('{due: cyc + 2, data: model_mem[addr[g]]});
            else   q0.push_back('{due: cyc + 2, data: model_mem[addr[g]]});
          end
        end
      end
    end
  end

  // ---------------- requester drivers ----------------
  task automatic issue(input int r, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input bit may_drop);
    bit got = 1'b0;
    req[r] = 1'b1; wr[r] = w; addr[r] = a; wdata[r] = d;
    for (int n = 0; n < (may_drop ? 1 : 40) && !got; n++) begin
      @(posedge clk); #1;
      got = (r == 0) ? ack0 : ack1;
    end
    req[r] = 1'b0;
    if (!got && !may_drop) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout req%0d got no ack want ack within 40 cycles", r);
    end
  endtask

  task automatic random_traffic(input int r, input int n_cmd);
    for (int i = 0; i < n_cmd; i++) begin
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      issue(r, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)),
            DW'($urandom), ($urandom_range(0, 7) == 0));
    end
  endtask

  initial begin
    time t0;
    rst_n = 1'b0;
    req = 2'b00; wr = 2'b00;
    addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;

    // Reset held with both requesters pending
    req = 2'b11; addr[1] = AW'(1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    fork
      issue(0, 1'b0, AW'(0), '0, 1'b0);
      issue(1, 1'b0, AW'(1), '0, 1'b0);
    join

    // Write then read back through requester 0
    issue(0, 1'b1, AW'(7), DW'(5), 1'b0);
    issue(0, 1'b0, AW'(7), '0, 1'b0);
    repeat (3) begin @(posedge clk); #1; end

    // Lone requester held back-to-back: one ack every other cycle
    t0 = $time;
    repeat (4) issue(0, 1'b0, AW'(7), '0, 1'b0);
    check("b2b_cycles", 32'(($time - t0) / 10), 32'd7);

    // Continuous contention
    fork
      repeat (6) issue(0, 1'b0, AW'(7), '0, 1'b0);
      repeat (6) issue(1, 1'b0, AW'(7), '0, 1'b0);
    join

    // Cross-requester write followed immediately by read
    issue(1, 1'b1, AW'(10), DW'(16'h1234), 1'b0);
    issue(0, 1'b0, AW'(10), '0, 1'b0);
    repeat (3) begin @(posedge clk); #1; end

    // Reset the cycle after a read ack: result dropped, contents kept
    issue(0, 1'b0, AW'(10), '0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    issue(0, 1'b0, AW'(10), '0, 1'b0);

    // Write pending while reset asserted never reaches the BRAM
    req[1] = 1'b1; wr[1] = 1'b1; addr[1] = AW'(20); wdata[1] = DW'(16'hdead);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; req[1] = 1'b0;
    issue(0, 1'b0, AW'(20), '0, 1'b0);
    repeat (3) begin @(posedge clk); #1; end

    fork
      random_traffic(0, 200);
      random_traffic(1, 200);
    join
    repeat (6) begin @(posedge clk); #1; end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #(500000);
    $display("FAIL global_timeout sim time exceeded want finish before 500000");
    $fatal(1, "timeout");
  end

endmodule
